// File: rtl/cycapuf_eval_ctrl.sv
// Controlled-evaluation wrapper around a bank of cyclic arbiter PUF instances.
//
// A challenge is accepted through a valid/ready handshake and then evaluated VOTES
// times. Each evaluation seeds the cyclic challenge bits from the latched challenge,
// lets the arbiters settle, captures them, and optionally feeds the captured
// outputs back (bit-reversed, XORed with the challenge) for ROUNDS extra rounds.
// The XOR of all arbiter outputs at the last capture of each evaluation is one
// vote. The majority vote and a "votes disagreed" flag are returned through a
// second valid/ready handshake.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   chal        challenge, sampled only on the chal_valid/chal_ready handshake
//   chal_valid  challenge offered
//   chal_ready  idle, a challenge will be accepted
//   resp        majority-voted response bit
//   vote_cnt    number of evaluations that produced 1
//   unstable    votes were not unanimous
//   resp_valid  resp/vote_cnt/unstable valid
//   resp_ready  collector accepts the response
//   busy        evaluation in progress
//
// Each g_apuf instance and the feedback nets are meant to be preserved by
// synthesis constraints so that symmetric arbiter paths are not merged.
module cycapuf_eval_ctrl #(
  parameter int unsigned CHAL_W  = 37,
  parameter int unsigned CYC_W   = 25,
  parameter int unsigned NUM_PUF = 37,
  parameter int unsigned ROUNDS  = 1,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned VOTES   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHAL_W-1:0] chal,
  input  logic              chal_valid,
  output logic              chal_ready,
  output logic              resp,
  output logic [3:0]        vote_cnt,
  output logic              unstable,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              busy
);

  localparam int unsigned RndW    = (ROUNDS > 0) ? $clog2(ROUNDS + 1) : 1;
  localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StSettle,
    StCapture,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CHAL_W-1:0]   ch_q, ch_d;
  logic [CYC_W-1:0]    cycle_q, cycle_d;
  logic [CYC_W-1:0]    cycle_fb;
  logic [RndW-1:0]     round_q, round_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [3:0]          vidx_q, vidx_d;
  logic [3:0]          vcnt_q, vcnt_d;
  logic                resp_q, resp_d;
  logic                unst_q, unst_d;
  logic [NUM_PUF-1:0]  puf_out;
  logic                puf_par;

  // Arbiter bank. Each instance is modelled behaviourally as X ^ ^Chal; the
  // physical design replaces this body with the hand-placed arbiter chain.
  for (genvar i = 0; i < NUM_PUF; i++) begin : g_apuf
    logic [CHAL_W-1:0] apuf_chal;
    if (CYC_W == CHAL_W) begin : g_full_cyc
      assign apuf_chal = cycle_q;
    end else begin : g_part_cyc
      assign apuf_chal = {ch_q[CHAL_W-1:CYC_W], cycle_q};
    end
    assign puf_out[i] = cycle_q[i % CYC_W] ^ (^apuf_chal);
  end

  // puf_out is only ever consumed on the CAPTURE transition below.
  assign puf_par = ^puf_out;

  // Feedback: bit-reversed arbiter outputs XORed into the original challenge bits.
  always_comb begin
    cycle_fb = '0;
    for (int j = 0; j < int'(CYC_W); j++) begin
      cycle_fb[j] = ch_q[j] ^ puf_out[int'(CYC_W) - 1 - j];
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cycle_d  = cycle_q;
    round_d  = round_q;
    settle_d = settle_q;
    vidx_d   = vidx_q;
    vcnt_d   = vcnt_q;
    resp_d   = resp_q;
    unst_d   = unst_q;

    unique case (state_q)
      StIdle: begin
        if (chal_valid) begin
          ch_d    = chal;
          vcnt_d  = '0;
          vidx_d  = '0;
          state_d = StInit;
        end
      end
      StInit: begin
        cycle_d  = ch_q[CYC_W-1:0];
        round_d  = '0;
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == SettleW'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = StCapture;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StCapture: begin
        if (int'(round_q) < int'(ROUNDS)) begin
          cycle_d = cycle_fb;
          round_d = round_q + 1'b1;
          state_d = StSettle;
        end else begin
          if (vcnt_q != 4'd15) begin
            vcnt_d = vcnt_q + {3'b000, puf_par};
          end
          if (int'(vidx_q) < int'(VOTES) - 1) begin
            vidx_d  = vidx_q + 1'b1;
            state_d = StInit;
          end else begin
            // resp/unstable only change on entry to DONE so they persist
            // across the idle period after the handshake.
            resp_d  = (vcnt_d > 4'(VOTES / 2));
            unst_d  = (vcnt_d != 4'd0) && (vcnt_d != 4'(VOTES));
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      cycle_q  <= '0;
      round_q  <= '0;
      settle_q <= '0;
      vidx_q   <= '0;
      vcnt_q   <= '0;
      resp_q   <= 1'b0;
      unst_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cycle_q  <= cycle_d;
      round_q  <= round_d;
      settle_q <= settle_d;
      vidx_q   <= vidx_d;
      vcnt_q   <= vcnt_d;
      resp_q   <= resp_d;
      unst_q   <= unst_d;
    end
  end

  assign chal_ready = (state_q == StIdle);
  assign resp_valid = (state_q == StDone);
  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign resp       = resp_q;
  assign unstable   = unst_q;
  assign vote_cnt   = vcnt_q;

endmodule

// File: tb/tb_cycapuf_eval_ctrl.sv
// Self-checking bench for cycapuf_eval_ctrl: default configuration plus a
// ROUNDS=0/SETTLE=1/VOTES=1 instance, random challenges against a reference
// model of the evaluation rules.
module tb_cycapuf_eval_ctrl;

  localparam int CHAL_W  = 37;
  localparam int CYC_W   = 25;
  localparam int NUM_PUF = 37;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;

  logic [CHAL_W-1:0] chal = '0;
  logic              chal_valid = 1'b0;
  logic              chal_ready;
  logic              resp;
  logic [3:0]        vote_cnt;
  logic              unstable;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic              busy;

  logic [CHAL_W-1:0] s_chal = '0;
  logic              s_chal_valid = 1'b0;
  logic              s_chal_ready;
  logic              s_resp;
  logic [3:0]        s_vote_cnt;
  logic              s_unstable;
  logic              s_resp_valid;
  logic              s_resp_ready = 1'b1;
  logic              s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cycapuf_eval_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chal       (chal),
    .chal_valid (chal_valid),
    .chal_ready (chal_ready),
    .resp       (resp),
    .vote_cnt   (vote_cnt),
    .unstable   (unstable),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  cycapuf_eval_ctrl #(
    .ROUNDS (0),
    .SETTLE (1),
    .VOTES  (1)
  ) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .chal       (s_chal),
    .chal_valid (s_chal_valid),
    .chal_ready (s_chal_ready),
    .resp       (s_resp),
    .vote_cnt   (s_vote_cnt),
    .unstable   (s_unstable),
    .resp_valid (s_resp_valid),
    .resp_ready (s_resp_ready),
    .busy       (s_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arbiter bank: every instance answers X ^ parity(challenge).
  function automatic logic [NUM_PUF-1:0] model_puf(input logic [CHAL_W-1:0] ch,
                                                   input logic [CYC_W-1:0] cyc);
    logic [NUM_PUF-1:0] r;
    logic               p;
    p = ^{ch[CHAL_W-1:CYC_W], cyc};
    for (int i = 0; i < NUM_PUF; i++) r[i] = cyc[i % CYC_W] ^ p;
    return r;
  endfunction

  // One evaluation: seed, apply `rounds` reversed-XOR feedback steps, vote = parity.
  function automatic logic model_eval(input logic [CHAL_W-1:0] ch, input int rounds);
    logic [CYC_W-1:0]   cyc;
    logic [NUM_PUF-1:0] o;
    cyc = ch[CYC_W-1:0];
    for (int r = 0; r < rounds; r++) begin
      o = model_puf(ch, cyc);
      for (int j = 0; j < CYC_W; j++) cyc[j] = ch[j] ^ o[CYC_W-1-j];
    end
    o = model_puf(ch, cyc);
    return ^o;
  endfunction

  function automatic logic [CHAL_W-1:0] rand_chal();
    logic [CHAL_W-1:0] c;
    c = {5'($urandom), 32'($urandom)};
    return c;
  endfunction

  // Offer a challenge to the default instance and count edges until resp_valid.
  task automatic start_and_wait(input logic [CHAL_W-1:0] ch, output int lat);
    chal       = ch;
    chal_valid = 1'b1;
    @(posedge clk); #1;
    chal_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic eval_big(input logic [CHAL_W-1:0] ch, input string tag);
    int   lat;
    logic exp;
    exp = model_eval(ch, 1);
    start_and_wait(ch, lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'd33);
    check_eq({tag, "_resp"}, 64'(resp), 64'(exp));
    check_eq({tag, "_vcnt"}, 64'(vote_cnt), exp ? 64'd3 : 64'd0);
    check_eq({tag, "_unst"}, 64'(unstable), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_rv_low"}, 64'(resp_valid), 64'd0);
    check_eq({tag, "_rdy_hi"}, 64'(chal_ready), 64'd1);
  endtask

  task automatic eval_small(input logic [CHAL_W-1:0] ch, input string tag);
    int   lat;
    logic exp;
    exp = model_eval(ch, 0);
    s_chal       = ch;
    s_chal_valid = 1'b1;
    @(posedge clk); #1;
    s_chal_valid = 1'b0;
    lat = 0;
    while (!s_resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd3);
    check_eq({tag, "_resp"}, 64'(s_resp), 64'(exp));
    check_eq({tag, "_vcnt"}, 64'(s_vote_cnt), 64'(exp));
    @(posedge clk); #1;
    check_eq({tag, "_rv_low"}, 64'(s_resp_valid), 64'd0);
  endtask

  initial begin
    int   lat;
    logic exp;
    logic held_resp;
    logic [3:0] held_cnt;
    int   seen;

    // Reset held with a challenge offered.
    chal       = 37'h1F_0000_00AA;
    chal_valid = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_chal_ready", 64'(chal_ready), 64'd1);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_vote_cnt", 64'(vote_cnt), 64'd0);
    check_eq("rst_resp", 64'(resp), 64'd0);
    check_eq("rst_unstable", 64'(unstable), 64'd0);
    chal_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_idle", 64'(busy), 64'd0);

    // Directed challenge with backpressure on the response.
    resp_ready = 1'b0;
    exp = model_eval(37'h0_0000_0001, 1);
    start_and_wait(37'h0_0000_0001, lat);
    check_eq("dir_lat", 64'(lat), 64'd33);
    check_eq("dir_resp", 64'(resp), 64'(exp));
    check_eq("dir_vcnt", 64'(vote_cnt), exp ? 64'd3 : 64'd0);
    check_eq("dir_unst", 64'(unstable), 64'd0);
    held_resp  = resp;
    held_cnt   = vote_cnt;
    chal       = 37'h15_5555_5555;
    chal_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check_eq("bp_chal_ready", 64'(chal_ready), 64'd0);
    end
    check_eq("bp_resp_valid", 64'(resp_valid), 64'd1);
    check_eq("bp_resp", 64'(resp), 64'(held_resp));
    check_eq("bp_vcnt", 64'(vote_cnt), 64'(held_cnt));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chal_valid = 1'b0;
    check_eq("hs_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("hs_chal_ready", 64'(chal_ready), 64'd1);
    check_eq("hs_resp_kept", 64'(resp), 64'(exp));
    @(posedge clk); #1;
    check_eq("hs_ignored", 64'(busy), 64'd0);

    // Random challenges, default configuration.
    for (int n = 0; n < 8; n++) eval_big(rand_chal(), "rnd");

    // Forced arbiter outputs to produce votes 1,0,1.
    chal       = rand_chal();
    chal_valid = 1'b1;
    @(posedge clk); #1;
    chal_valid = 1'b0;
    force dut.puf_out = 37'h1;
    repeat (11) @(posedge clk);
    #1 force dut.puf_out = 37'h0;
    repeat (11) @(posedge clk);
    #1 force dut.puf_out = 37'h3_0000_0001;
    repeat (11) @(posedge clk);
    #1 release dut.puf_out;
    check_eq("vote_rv", 64'(resp_valid), 64'd1);
    check_eq("vote_cnt", 64'(vote_cnt), 64'd2);
    check_eq("vote_resp", 64'(resp), 64'd1);
    check_eq("vote_unst", 64'(unstable), 64'd1);
    @(posedge clk); #1;
    check_eq("vote_unst_kept", 64'(unstable), 64'd1);

    // ROUNDS=0, SETTLE=1, VOTES=1 instance.
    eval_small(37'h0_0000_0001, "sm_dir");
    for (int n = 0; n < 4; n++) eval_small(rand_chal(), "sm_rnd");

    // Reset mid-evaluation.
    chal       = rand_chal();
    chal_valid = 1'b1;
    @(posedge clk); #1;
    chal_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_ready", 64'(chal_ready), 64'd1);
    check_eq("mid_rst_vcnt", 64'(vote_cnt), 64'd0);
    check_eq("mid_rst_resp", 64'(resp), 64'd0);
    check_eq("mid_rst_unst", 64'(unstable), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    check_eq("mid_rst_no_resp", 64'(seen), 64'd0);
    eval_big(rand_chal(), "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cycapuf_eval_ctrl.md
Name: cycapuf_eval_ctrl

Overview:
- Parametrised, controlled-evaluation successor to the free-running one-bit cyclic arbiter PUF top.
- Latches a challenge through a valid/ready handshake, then runs a bounded number of feedback rounds through NUM_PUF APUF instances.
- Repeats the evaluation VOTES times and returns a majority-voted response bit plus a stability flag through a second valid/ready handshake.
- Sits between the challenge source (UART/test host) and the response collector.

Parameters:
- CHAL_W, 37, challenge width in bits; must be >= CYC_W.
- CYC_W, 25, number of feedback (cyclic) challenge bits; must be <= NUM_PUF.
- NUM_PUF, 37, number of APUF instances XORed into the response.
- ROUNDS, 1, feedback rounds per evaluation (0 = no feedback, single pass).
- SETTLE, 4, clocks allowed for arbiters to resolve before each capture (>= 1).
- VOTES, 3, evaluations per challenge; odd, 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- chal  input  CHAL_W  challenge; sampled only on handshake
- chal_valid  input  1  challenge offered
- chal_ready  output  1  block idle, will accept challenge
- resp  output  1  majority-voted response bit
- vote_cnt  output  4  number of evaluations that produced 1
- unstable  output  1  votes not unanimous
- resp_valid  output  1  resp/vote_cnt/unstable valid
- resp_ready  input  1  collector accepts response
- busy  output  1  evaluation in progress (not IDLE/DONE)

Behaviour:
- Reset (async assert, sync deassert): state IDLE, chal_ready=1, resp_valid=0, resp=0, vote_cnt=0, unstable=0, busy=0; ch_reg, cycle_reg, puf_q, all counters cleared.
- APUF instance i: X=cycle_reg[i mod CYC_W], Y=ch_reg[0], Chal={ch_reg[CHAL_W-1:CYC_W], cycle_reg}; if CYC_W==CHAL_W, Chal=cycle_reg. Outputs form puf_out[NUM_PUF-1:0].
- FSM: IDLE, INIT, SETTLE, CAPTURE, DONE.
- IDLE: chal_ready=1. On chal_valid&chal_ready: ch_reg<=chal, vote_cnt<=0, vote index<=0, go INIT. chal_valid in any other state is ignored and chal is not sampled.
- INIT (1 clk): cycle_reg<=ch_reg[CYC_W-1:0], round<=0, settle counter<=0, go SETTLE.
- SETTLE: counts SETTLE clocks, then go CAPTURE.
- CAPTURE (1 clk): puf_q<=puf_out.
  - If round<ROUNDS: cycle_reg[j]<=ch_reg[j]^puf_out[CYC_W-1-j] for j=0..CYC_W-1, round++, go SETTLE.
  - Else: vote_cnt<=vote_cnt+(^puf_out). If vote index<VOTES-1: index++, go INIT. Else go DONE.
- DONE: resp_valid=1, resp=(vote_cnt > VOTES/2), unstable=(vote_cnt!=0 && vote_cnt!=VOTES). Outputs are held stable while resp_ready=0. On resp_ready: resp_valid<=0, go IDLE; chal_ready rises the same edge.
- Latency: resp_valid rises exactly L = VOTES*(1+(ROUNDS+1)*(SETTLE+1)) clocks after the accepting edge. Defaults give L=33.
- vote_cnt saturates at 15. resp and unstable retain their last values after the handshake until the next DONE.
- ROUNDS=0: no cycle_reg update; each evaluation is one settle plus one capture.
- Reset mid-operation: immediate return to reset values; the partial vote is discarded and no resp_valid is produced.
- Arbiter outputs are sampled only in CAPTURE. puf_out must not drive any other logic directly.
- All APUF instances and feedback nets are kept (dont_touch) so synthesis cannot merge symmetric paths.

Test Plan:
- Reset: hold rst_n=0 with chal_valid=1 -> chal_ready=1, resp_valid=0, busy=0, vote_cnt=0. Deassert -> nothing accepted until the first edge with chal_valid=1.
- Latency, defaults, with a behavioural APUF model (out_Q = X ^ ^Chal): chal=37'h0_0000_0001 accepted at edge 0 -> resp_valid rises at edge 33. resp and vote_cnt match the golden model computed with the reversed-XOR feedback.
- Deterministic model -> vote_cnt is 0 or 3 and unstable=0. Model randomised per call forced to the vote pattern 1,0,1 -> vote_cnt=2, resp=1, unstable=1.
- Backpressure: resp_ready=0 for 10 clocks after resp_valid -> outputs stable, chal_ready=0, a second chal_valid is ignored. resp_ready=1 -> next edge resp_valid=0, chal_ready=1.
- ROUNDS=0, SETTLE=1, VOTES=1 -> L=3. cycle_reg equals chal[24:0] at CAPTURE.
- rst_n pulsed low at edge 15 of an evaluation -> all outputs return to reset values asynchronously and no resp_valid appears. A new challenge then completes normally with L=33.
